// File: rtl/conv_bram_arbiter_pkg.sv
// Shared constants and encodings for the conv/host image BRAM arbiter.
package conv_bram_arbiter_pkg;

  localparam int unsigned AW        = 15;
  localparam int unsigned DW        = 8;
  localparam int unsigned MAX_BURST = 9;

  typedef enum logic {
    OWNER_CONV = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/conv_bram_arbiter_rd_tag_pipe.sv
// Delays each read tag by the BRAM read latency so returned data is steered to
// the requester that issued the read, even after the grant has moved on.
module conv_bram_arbiter_rd_tag_pipe
  import conv_bram_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push,
  output logic    rvalid0,
  output logic    rvalid1
);

  rd_tag_t stage [RD_LAT];

  // Reset flushes in-flight reads so none are reported after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LAT); i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < int'(RD_LAT); i++) stage[i] <= stage[i-1];
    end
  end

  assign rvalid0 = stage[RD_LAT-1].valid && (stage[RD_LAT-1].owner == OWNER_CONV);
  assign rvalid1 = stage[RD_LAT-1].valid && (stage[RD_LAT-1].owner == OWNER_HOST);

endmodule

// File: rtl/conv_bram_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port image BRAM
// between the convolution engine (0) and the host/readout side (1).
module conv_bram_arbiter #(
  parameter int unsigned AW        = conv_bram_arbiter_pkg::AW,
  parameter int unsigned DW        = conv_bram_arbiter_pkg::DW,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = conv_bram_arbiter_pkg::MAX_BURST
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          bram_ena,
  output logic          bram_wea,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout,
  output logic          busy
);
  import conv_bram_arbiter_pkg::*;

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  state_e        state;
  owner_e        last_owner;
  logic [CW-1:0] beat_cnt;
  logic          beat0;
  logic          beat1;
  logic          at_limit;
  logic [CW-1:0] cnt_inc;
  rd_tag_t       push_tag;

  assign beat0    = (state == OWN0) && req0;
  assign beat1    = (state == OWN1) && req1;
  assign at_limit = beat_cnt >= CW'(MAX_BURST - 1);
  assign cnt_inc  = (beat_cnt >= CW'(MAX_BURST)) ? beat_cnt : beat_cnt + CW'(1);

  // Grant FSM; a saturated owner yields on its next beat once the other side asks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= OWNER_HOST;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_owner == OWNER_HOST)) state <= OWN0;
          else if (req1)                                   state <= OWN1;
        end
        OWN0: begin
          if (!req0 || (at_limit && req1)) begin
            state      <= req1 ? OWN1 : IDLE;
            last_owner <= OWNER_CONV;
            beat_cnt   <= '0;
          end else begin
            beat_cnt <= cnt_inc;
          end
        end
        OWN1: begin
          if (!req1 || (at_limit && req0)) begin
            state      <= req0 ? OWN0 : IDLE;
            last_owner <= OWNER_HOST;
            beat_cnt   <= '0;
          end else begin
            beat_cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);
  assign busy = (state != IDLE);

  // BRAM port follows the owner's beat; quiet and zeroed otherwise.
  always_comb begin
    bram_ena  = 1'b0;
    bram_wea  = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (beat0) begin
      bram_ena  = 1'b1;
      bram_wea  = we0;
      bram_addr = addr0;
      bram_din  = wdata0;
    end else if (beat1) begin
      bram_ena  = 1'b1;
      bram_wea  = we1;
      bram_addr = addr1;
      bram_din  = wdata1;
    end
  end

  always_comb begin
    push_tag       = '0;
    push_tag.valid = (beat0 && !we0) || (beat1 && !we1);
    push_tag.owner = beat1 ? OWNER_HOST : OWNER_CONV;
  end

  conv_bram_arbiter_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_tag),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1)
  );

  assign rdata = bram_dout;

endmodule
